vliw_regfile_2w4r: RTL and testbench
====================================

Name: vliw_regfile_2w4r

Overview:
- Architectural register file for the two-slot VLIW datapath: 32 x 32-bit registers, 4 read ports (two per slot), 2 write ports (one per slot).
- Receiving end of the ALU/adder result path. Read data feeds the operand muxes.
- Integrated busy-bit scoreboard raises a stall when a slot reads a register whose pending write has not yet retired.
- Read-side write-through bypass removes the one-cycle write-to-read bubble.

Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register index width
- NUM_REGS, 32, register count (2**ADDR_W); r0 hardwired to zero
- BYPASS_EN, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- rdEn0..rdEn3  in  1 each  read port valid (ports 0/1 = slot 0, ports 2/3 = slot 1)
- rdAddr0..rdAddr3  in  ADDR_W each  read register index
- rdData0..rdData3  out  DATA_W each  read data (combinational)
- wrEn0, wrEn1  in  1 each  write enable for slot 0 / slot 1
- wrAddr0, wrAddr1  in  ADDR_W each  write index
- wrData0, wrData1  in  DATA_W each  write data
- issueEn0, issueEn1  in  1 each  instruction issued with a destination; marks the destination pending
- issueDst0, issueDst1  in  ADDR_W each  destination of the issued instruction
- stall  out  1  a valid read hits a pending register with no bypass available
- busyVec  out  NUM_REGS  scoreboard state, for debug

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset: on a rising edge with reset=1, all registers are 0 and busyVec=0. Reset overrides any write or issue in the same cycle. After reset, rdData*=0 and stall=0.
- Reads are combinational, with zero latency from rdAddr/wr* to rdData.
  - rdAddr=0 always returns 0.
  - When BYPASS_EN=1, forwarding is checked in this order: slot 1 write (wrEn1, wrAddr1==rdAddr, rdAddr!=0) returns wrData1; otherwise the slot 0 write returns wrData0; otherwise the stored value is returned.
  - rdData is driven regardless of rdEn; rdEn only qualifies stall.
- Writes commit on the rising edge.
  - A write to r0 is discarded.
  - If wrEn0 and wrEn1 target the same address, slot 1 wins (later in the bundle). The slot 0 write is dropped.
- Scoreboard: one busy bit per register, updated on the rising edge.
  - A write (wrEnN, wrAddrN!=0) clears busy[wrAddrN].
  - An issue (issueEnN, issueDstN!=0) sets busy[issueDstN].
  - Set and clear of the same register in the same cycle: the set wins, because a new producer is in flight.
  - busy[0] is always 0.
  - Both issue slots naming the same destination set the bit once. No error is flagged.
- Stall is combinational. stall=1 iff some port k has rdEnk=1, rdAddrk!=0 and busy[rdAddrk]=1, and that read is not satisfied by a same-cycle write.
  - With BYPASS_EN=0, a same-cycle write does not cancel the stall.
- Issue gating: the block does not gate issueEn on stall; upstream must hold the bundle and deassert issueEn while stall=1.
- Write port usage is unrestricted: no limit on writes per register per cycle beyond the conflict rule above.

Decomposition:
- vliw_pkg holds DATA_W, ADDR_W, NUM_REGS, NUM_SLOTS=2, ZERO_REG=0 and the slot-priority constant SLOT_HI=1.
- Sub-module regfile_read_port: one read port's bypass mux plus its per-port stall term. It is instantiated four times.
- Storage and the scoreboard stay in the top module.

Test Plan:
- Reset with wrEn0=1, wrAddr0=3, wrData0=0xDEAD in the same cycle -> r3 reads 0 and busyVec=0 next cycle.
- Write wrAddr0=5, wrData0=0x1234. Same cycle rdAddr0=5 -> 0x1234 (bypass). Next cycle rdAddr2=5 -> 0x1234 from storage. Write 0xFFFF to r0 -> r0 still reads 0.
- Same cycle: wrEn0 r7=0x11 and wrEn1 r7=0x22 -> rdAddr1=7 returns 0x22 in that cycle and after.
- issueEn0, issueDst0=9. Next cycle rdEn3=1, rdAddr3=9 -> stall=1. When wrEn1 r9=0xABCD arrives -> stall=0 that cycle, rdData3=0xABCD, and busy[9] clears next cycle.
- Same cycle: issueEn1 dst 4 and wrEn0 r4 -> busy[4]=1 next cycle. A rdEn0 read of r4 then stalls.
- BYPASS_EN=0: write r6=0x55 with same-cycle read of r6 -> returns old value 0. If busy[6] was set -> stall=1 for that cycle, and 0 the following cycle.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared constants, types and a decode helper for the two-slot VLIW register file.
package vliw_pkg;
    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;
    localparam int NUM_REGS     = 2 ** ADDR_W;
    localparam int NUM_SLOTS    = 2;
    localparam int NUM_RD_PORTS = 4;
    localparam int SLOT_HI      = 1;
    localparam int SLOT_LO      = 0;

    localparam logic [ADDR_W-1:0] ZERO_REG = {ADDR_W{1'b0}};

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // One-hot register select; r0 never decodes so it can be neither written nor marked busy.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic en, input addr_t addr);
        reg_onehot = {NUM_REGS{1'b0}};
        if (en && (addr != ZERO_REG)) begin
            reg_onehot[addr] = 1'b1;
        end else begin
            reg_onehot = {NUM_REGS{1'b0}};
        end
    endfunction
endpackage

// File: rtl/regfile_read_port.sv
// One read port: write-through bypass mux in slot order plus this port's stall term.
module regfile_read_port
    import vliw_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                            i_rd_en,
    input  logic [ADDR_W-1:0]               i_rd_addr,
    input  logic [DATA_W-1:0]               i_stored,
    input  logic                            i_busy,
    input  logic [NUM_SLOTS-1:0]            i_wr_en,
    input  logic [NUM_SLOTS-1:0][ADDR_W-1:0] i_wr_addr,
    input  logic [NUM_SLOTS-1:0][DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0]               o_rd_data,
    output logic                            o_stall
);
    logic w_nonzero;
    logic w_hit_hi;
    logic w_hit_lo;

    // The later slot in the bundle is checked first so it shadows slot 0 on a shared target.
    always_comb begin
        w_nonzero = (i_rd_addr != ZERO_REG);
        w_hit_hi  = BYPASS_EN && w_nonzero && i_wr_en[SLOT_HI] && (i_wr_addr[SLOT_HI] == i_rd_addr);
        w_hit_lo  = BYPASS_EN && w_nonzero && i_wr_en[SLOT_LO] && (i_wr_addr[SLOT_LO] == i_rd_addr);
        o_rd_data = {DATA_W{1'b0}};
        if (!w_nonzero) begin
            o_rd_data = {DATA_W{1'b0}};
        end else if (w_hit_hi) begin
            o_rd_data = i_wr_data[SLOT_HI];
        end else if (w_hit_lo) begin
            o_rd_data = i_wr_data[SLOT_LO];
        end else begin
            o_rd_data = i_stored;
        end
        o_stall = i_rd_en && w_nonzero && i_busy && !(w_hit_hi || w_hit_lo);
    end
endmodule

// File: rtl/vliw_regfile_2w4r.sv
// 32x32 register file, 4 read / 2 write ports, with busy-bit scoreboard and stall generation.
module vliw_regfile_2w4r
    import vliw_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rdEn0,
    input  logic                rdEn1,
    input  logic                rdEn2,
    input  logic                rdEn3,
    input  logic [ADDR_W-1:0]   rdAddr0,
    input  logic [ADDR_W-1:0]   rdAddr1,
    input  logic [ADDR_W-1:0]   rdAddr2,
    input  logic [ADDR_W-1:0]   rdAddr3,
    output logic [DATA_W-1:0]   rdData0,
    output logic [DATA_W-1:0]   rdData1,
    output logic [DATA_W-1:0]   rdData2,
    output logic [DATA_W-1:0]   rdData3,
    input  logic                wrEn0,
    input  logic                wrEn1,
    input  logic [ADDR_W-1:0]   wrAddr0,
    input  logic [ADDR_W-1:0]   wrAddr1,
    input  logic [DATA_W-1:0]   wrData0,
    input  logic [DATA_W-1:0]   wrData1,
    input  logic                issueEn0,
    input  logic                issueEn1,
    input  logic [ADDR_W-1:0]   issueDst0,
    input  logic [ADDR_W-1:0]   issueDst1,
    output logic                stall,
    output logic [NUM_REGS-1:0] busyVec
);
    logic [DATA_W-1:0]                   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]                 r_busy;

    logic [NUM_SLOTS-1:0]                w_wr_en;
    logic [NUM_SLOTS-1:0][ADDR_W-1:0]    w_wr_addr;
    logic [NUM_SLOTS-1:0][DATA_W-1:0]    w_wr_data;
    logic [NUM_SLOTS-1:0][NUM_REGS-1:0]  w_wr_hit;
    logic [NUM_REGS-1:0]                 w_clr_mask;
    logic [NUM_REGS-1:0]                 w_set_mask;
    logic [NUM_REGS-1:0]                 w_busy_nxt;

    logic [NUM_RD_PORTS-1:0]             w_rd_en;
    logic [NUM_RD_PORTS-1:0][ADDR_W-1:0] w_rd_addr;
    logic [NUM_RD_PORTS-1:0][DATA_W-1:0] w_rd_data;
    logic [NUM_RD_PORTS-1:0]             w_port_stall;

    assign w_wr_en   = {wrEn1, wrEn0};
    assign w_wr_addr = {wrAddr1, wrAddr0};
    assign w_wr_data = {wrData1, wrData0};
    assign w_rd_en   = {rdEn3, rdEn2, rdEn1, rdEn0};
    assign w_rd_addr = {rdAddr3, rdAddr2, rdAddr1, rdAddr0};

    assign w_wr_hit[SLOT_LO] = reg_onehot(wrEn0, wrAddr0);
    assign w_wr_hit[SLOT_HI] = reg_onehot(wrEn1, wrAddr1);
    assign w_clr_mask = w_wr_hit[SLOT_LO] | w_wr_hit[SLOT_HI];
    assign w_set_mask = reg_onehot(issueEn0, issueDst0) | reg_onehot(issueEn1, issueDst1);
    // A new producer issued this cycle outranks the retiring write of the same register.
    assign w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;

    // Register storage; slot 1 overrides slot 0 on a shared destination.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_hit[SLOT_HI][i]) begin
                    r_regs[i] <= w_wr_data[SLOT_HI];
                end else if (w_wr_hit[SLOT_LO][i]) begin
                    r_regs[i] <= w_wr_data[SLOT_LO];
                end else begin
                    r_regs[i] <= r_regs[i];
                end
            end
        end
    end

    // Scoreboard busy bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= {NUM_REGS{1'b0}};
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
        regfile_read_port #(
            .BYPASS_EN (BYPASS_EN)
        ) u_port (
            .i_rd_en   (w_rd_en[k]),
            .i_rd_addr (w_rd_addr[k]),
            .i_stored  (r_regs[w_rd_addr[k]]),
            .i_busy    (r_busy[w_rd_addr[k]]),
            .i_wr_en   (w_wr_en),
            .i_wr_addr (w_wr_addr),
            .i_wr_data (w_wr_data),
            .o_rd_data (w_rd_data[k]),
            .o_stall   (w_port_stall[k])
        );
    end

    assign rdData0 = w_rd_data[0];
    assign rdData1 = w_rd_data[1];
    assign rdData2 = w_rd_data[2];
    assign rdData3 = w_rd_data[3];
    assign stall   = |w_port_stall;
    assign busyVec = r_busy;
endmodule

// File: tb/tb_vliw_regfile_2w4r.sv
// Directed bench: bypass-enabled and bypass-disabled instances share one stimulus stream.
module tb_vliw_regfile_2w4r;
    logic        clk = 1'b0;
    logic        reset;
    logic        rdEn0, rdEn1, rdEn2, rdEn3;
    logic [4:0]  rdAddr0, rdAddr1, rdAddr2, rdAddr3;
    logic        wrEn0, wrEn1;
    logic [4:0]  wrAddr0, wrAddr1;
    logic [31:0] wrData0, wrData1;
    logic        issueEn0, issueEn1;
    logic [4:0]  issueDst0, issueDst1;

    logic [31:0] rd0, rd1, rd2, rd3, nb_rd0, nb_rd1, nb_rd2, nb_rd3;
    logic        stall_b, nb_stall;
    logic [31:0] busy_b, nb_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vliw_regfile_2w4r #(.BYPASS_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .rdEn0(rdEn0), .rdEn1(rdEn1), .rdEn2(rdEn2), .rdEn3(rdEn3),
        .rdAddr0(rdAddr0), .rdAddr1(rdAddr1), .rdAddr2(rdAddr2), .rdAddr3(rdAddr3),
        .rdData0(rd0), .rdData1(rd1), .rdData2(rd2), .rdData3(rd3),
        .wrEn0(wrEn0), .wrEn1(wrEn1), .wrAddr0(wrAddr0), .wrAddr1(wrAddr1),
        .wrData0(wrData0), .wrData1(wrData1),
        .issueEn0(issueEn0), .issueEn1(issueEn1), .issueDst0(issueDst0), .issueDst1(issueDst1),
        .stall(stall_b), .busyVec(busy_b)
    );

    vliw_regfile_2w4r #(.BYPASS_EN(1'b0)) u_dut_nb (
        .clk(clk), .reset(reset),
        .rdEn0(rdEn0), .rdEn1(rdEn1), .rdEn2(rdEn2), .rdEn3(rdEn3),
        .rdAddr0(rdAddr0), .rdAddr1(rdAddr1), .rdAddr2(rdAddr2), .rdAddr3(rdAddr3),
        .rdData0(nb_rd0), .rdData1(nb_rd1), .rdData2(nb_rd2), .rdData3(nb_rd3),
        .wrEn0(wrEn0), .wrEn1(wrEn1), .wrAddr0(wrAddr0), .wrAddr1(wrAddr1),
        .wrData0(wrData0), .wrData1(wrData1),
        .issueEn0(issueEn0), .issueEn1(issueEn1), .issueDst0(issueDst0), .issueDst1(issueDst1),
        .stall(nb_stall), .busyVec(nb_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rdEn0 = 1'b0; rdEn1 = 1'b0; rdEn2 = 1'b0; rdEn3 = 1'b0;
        rdAddr0 = 5'd0; rdAddr1 = 5'd0; rdAddr2 = 5'd0; rdAddr3 = 5'd0;
        wrEn0 = 1'b0; wrEn1 = 1'b0; wrAddr0 = 5'd0; wrAddr1 = 5'd0;
        wrData0 = 32'd0; wrData1 = 32'd0;
        issueEn0 = 1'b0; issueEn1 = 1'b0; issueDst0 = 5'd0; issueDst1 = 5'd0;
    endtask

    // Advance one rising edge, then settle 1ns so sampling stays off the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        wrEn0 = 1'b1; wrAddr0 = 5'd3; wrData0 = 32'h0000_DEAD;
        issueEn0 = 1'b1; issueDst0 = 5'd3;
        step();
        reset = 1'b0;
        clear_inputs();
        rdEn0 = 1'b1; rdAddr0 = 5'd3;
        #1;
        chk("reset_r3", rd0, 32'd0);
        chk("reset_busy", busy_b, 32'd0);
        chk("reset_stall", {31'd0, stall_b}, 32'd0);
        chk("reset_nb_r3", nb_rd0, 32'd0);

        // write r5 with same-cycle read: bypass vs stored
        clear_inputs();
        wrEn0 = 1'b1; wrAddr0 = 5'd5; wrData0 = 32'h0000_1234; rdAddr0 = 5'd5;
        #1;
        chk("bypass_r5", rd0, 32'h0000_1234);
        chk("nb_old_r5", nb_rd0, 32'd0);
        step();
        clear_inputs();
        rdAddr2 = 5'd5;
        #1;
        chk("stored_r5", rd2, 32'h0000_1234);
        chk("nb_stored_r5", nb_rd2, 32'h0000_1234);

        // r0 write discarded
        clear_inputs();
        wrEn0 = 1'b1; wrAddr0 = 5'd0; wrData0 = 32'h0000_FFFF; rdAddr0 = 5'd0;
        #1;
        chk("r0_same_cycle", rd0, 32'd0);
        step();
        clear_inputs();
        #1;
        chk("r0_after", rd0, 32'd0);

        // both slots write r7: slot 1 wins
        clear_inputs();
        wrEn0 = 1'b1; wrAddr0 = 5'd7; wrData0 = 32'h0000_0011;
        wrEn1 = 1'b1; wrAddr1 = 5'd7; wrData1 = 32'h0000_0022;
        rdAddr1 = 5'd7;
        #1;
        chk("conflict_bypass", rd1, 32'h0000_0022);
        step();
        clear_inputs();
        rdAddr1 = 5'd7;
        #1;
        chk("conflict_stored", rd1, 32'h0000_0022);
        chk("nb_conflict_stored", nb_rd1, 32'h0000_0022);

        // issue r9, read stalls until slot 1 write arrives
        clear_inputs();
        issueEn0 = 1'b1; issueDst0 = 5'd9;
        step();
        clear_inputs();
        rdEn3 = 1'b1; rdAddr3 = 5'd9;
        #1;
        chk("busy_r9", busy_b, 32'h0000_0200);
        chk("stall_r9", {31'd0, stall_b}, 32'd1);
        step();
        wrEn1 = 1'b1; wrAddr1 = 5'd9; wrData1 = 32'h0000_ABCD;
        #1;
        chk("stall_r9_bypassed", {31'd0, stall_b}, 32'd0);
        chk("rd3_bypass", rd3, 32'h0000_ABCD);
        chk("nb_stall_r9_kept", {31'd0, nb_stall}, 32'd1);
        chk("nb_rd3_old", nb_rd3, 32'd0);
        step();
        clear_inputs();
        rdEn3 = 1'b1; rdAddr3 = 5'd9;
        #1;
        chk("busy_r9_clear", busy_b, 32'd0);
        chk("stall_r9_gone", {31'd0, stall_b}, 32'd0);
        chk("rd3_stored", rd3, 32'h0000_ABCD);

        // issue and retire r4 same cycle: set wins
        clear_inputs();
        issueEn1 = 1'b1; issueDst1 = 5'd4;
        wrEn0 = 1'b1; wrAddr0 = 5'd4; wrData0 = 32'h0000_0044;
        step();
        clear_inputs();
        rdEn0 = 1'b1; rdAddr0 = 5'd4;
        #1;
        chk("busy_r4_set_wins", busy_b, 32'h0000_0010);
        chk("stall_r4", {31'd0, stall_b}, 32'd1);
        chk("rd0_r4_stored", rd0, 32'h0000_0044);
        wrEn1 = 1'b1; wrAddr1 = 5'd4; wrData1 = 32'h0000_0045;
        step();
        clear_inputs();
        #1;
        chk("busy_r4_clear", busy_b, 32'd0);

        // bypass-disabled instance: pending r6 stays stalled through its write cycle
        clear_inputs();
        issueEn0 = 1'b1; issueDst0 = 5'd6;
        step();
        clear_inputs();
        wrEn0 = 1'b1; wrAddr0 = 5'd6; wrData0 = 32'h0000_0055;
        rdEn1 = 1'b1; rdAddr1 = 5'd6;
        #1;
        chk("nb_r6_old", nb_rd1, 32'd0);
        chk("nb_r6_stall", {31'd0, nb_stall}, 32'd1);
        chk("b_r6_nostall", {31'd0, stall_b}, 32'd0);
        chk("b_r6_bypass", rd1, 32'h0000_0055);
        step();
        clear_inputs();
        rdEn1 = 1'b1; rdAddr1 = 6'd6;
        #1;
        chk("nb_r6_stall_gone", {31'd0, nb_stall}, 32'd0);
        chk("nb_r6_stored", nb_rd1, 32'h0000_0055);

        // both slots issue r12; r0 issue ignored; disabled read never stalls
        clear_inputs();
        issueEn0 = 1'b1; issueDst0 = 5'd12;
        issueEn1 = 1'b1; issueDst1 = 5'd12;
        step();
        clear_inputs();
        issueEn0 = 1'b1; issueDst0 = 5'd0;
        rdEn2 = 1'b0; rdAddr2 = 5'd12;
        #1;
        chk("busy_r12_dual", busy_b, 32'h0000_1000);
        chk("no_stall_rden0", {31'd0, stall_b}, 32'd0);
        step();
        clear_inputs();
        rdEn0 = 1'b1; rdAddr0 = 5'd0;
        #1;
        chk("busy_r0_never", busy_b, 32'h0000_1000);
        chk("stall_r0_read", {31'd0, stall_b}, 32'd0);

        // mid-run reset clears storage and scoreboard
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        rdAddr2 = 5'd5; rdAddr1 = 5'd7;
        #1;
        chk("reset2_busy", busy_b, 32'd0);
        chk("reset2_r5", rd2, 32'd0);
        chk("reset2_r7", rd1, 32'd0);
        chk("reset2_nb_busy", nb_busy, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
